// File: rtl/xor_frame_parity.sv
// xor_frame_parity: accumulates a column-wise XOR over a frame of words
// and presents the frame's XOR, parity, saturating length and overflow
// flag as a single held result.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both 1. A producer holding valid=1 while ready=0 keeps its word
// stable, and the word is not consumed. in_last only has meaning
// alongside in_valid. out_* hold steady while out_valid=1 until out_ready=1.
module xor_frame_parity #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [0:0]       ACCUM   = 1'b0;
  localparam logic [0:0]       HOLD    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             ODD_BIT = (ODD != 0);

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic [WIDTH-1:0] acc_next;

  // Input is only taken while accumulating; HOLD blocks the producer,
  // including the cycle in which the result is popped.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Counter saturates at all-ones; overflow is sticky once a word arrives
  // while the counter is already saturated.
  assign cnt_sat  = (cnt == CNT_MAX);
  assign cnt_next = cnt_sat ? cnt : cnt + CNT_W'(1);
  assign ovf_next = ovf | cnt_sat;
  assign acc_next = acc ^ in_data;

  // Parity is derived from the registered result, so it is stable in HOLD.
  assign out_parity = (^out_data) ^ ODD_BIT;

  // Frame FSM: ACCUM folds words into the accumulator, the last word
  // loads the result registers and parks the block in HOLD until popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_data  <= acc_next;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
              ovf <= ovf_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Bench for xor_frame_parity. Two instances share the same stimulus:
// dut_a uses the defaults (CNT_W=8, even parity) and dut_b uses CNT_W=2
// with odd parity, so saturation and parity polarity are exercised together.
module tb_xor_frame_parity;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_parity_a, out_ovf_a;
  logic [7:0] out_data_a, out_count_a;
  logic       in_ready_b, out_valid_b, out_parity_b, out_ovf_b;
  logic [7:0] out_data_b;
  logic [1:0] out_count_b;

  logic [17:0] obs_a;
  logic [11:0] obs_b;
  logic [3:0]  hs;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [17:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];

  xor_frame_parity #(.WIDTH(8), .CNT_W(8), .ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_parity(out_parity_a),
    .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  xor_frame_parity #(.WIDTH(8), .CNT_W(2), .ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_parity(out_parity_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  assign obs_a = {out_data_a, out_parity_a, out_count_a, out_ovf_a};
  assign obs_b = {out_data_b, out_parity_b, out_count_b, out_ovf_b};
  assign hs    = {in_ready_a, in_ready_b, out_valid_a, out_valid_b};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: fold the frame held in frame_q from first principles.
  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    return x;
  endfunction

  function automatic logic [17:0] exp_a();
    logic [7:0] d = frame_xor();
    int len = frame_q.size();
    int c = (len > 255) ? 255 : len;
    return {d, ^d, 8'(c), (len > 255)};
  endfunction

  function automatic logic [11:0] exp_b();
    logic [7:0] d = frame_xor();
    int len = frame_q.size();
    int c = (len > 3) ? 3 : len;
    return {d, ~(^d), 2'(c), (len > 3)};
  endfunction

  // Driver: sends frame_q; gap_mode 0 = none, 1 = random idles, 2 = idle
  // before every word. Idle cycles carry junk data and a random in_last.
  // Returns at the falling edge after the last word was accepted.
  task automatic send_frame(input int gap_mode);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hs !== 4'b1100) begin
      errors++; $display("FAIL reset_handshake: got %b expected %b", hs, 4'b1100);
    end
    checks++;
    if (obs_a !== 18'h0 || obs_b !== {8'h00, 1'b1, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_outputs: got a=%h b=%h expected a=0 b=%h", obs_a, obs_b, {8'h00, 1'b1, 2'd0, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    out_ready = 1'b1;
    frame_q = '{8'h0F, 8'hF0, 8'h3C};
    send_frame(0);
    checks++;
    if (hs !== 4'b0011) begin
      errors++; $display("FAIL basic_latency: got %b expected %b", hs, 4'b0011);
    end
    checks++;
    if (obs_a !== {8'hC3, 1'b0, 8'd3, 1'b0}) begin
      errors++; $display("FAIL basic_result_a: got %h expected %h", obs_a, {8'hC3, 1'b0, 8'd3, 1'b0});
    end
    checks++;
    if (obs_b !== {8'hC3, 1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL basic_result_b: got %h expected %h", obs_b, {8'hC3, 1'b1, 2'd3, 1'b0});
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (hs !== 4'b1100) begin
      errors++; $display("FAIL basic_return_accum: got %b expected %b", hs, 4'b1100);
    end
  endtask

  task automatic test_single_word();
    frame_q = '{8'h01};
    send_frame(0);
    checks++;
    if (obs_a !== {8'h01, 1'b1, 8'd1, 1'b0} || out_valid_a !== 1'b1) begin
      errors++; $display("FAIL single_a: got %h v=%b expected %h v=1", obs_a, out_valid_a, {8'h01, 1'b1, 8'd1, 1'b0});
    end
    checks++;
    if (obs_b !== {8'h01, 1'b0, 2'd1, 1'b0} || out_valid_b !== 1'b1) begin
      errors++; $display("FAIL single_b: got %h v=%b expected %h v=1", obs_b, out_valid_b, {8'h01, 1'b0, 2'd1, 1'b0});
    end
    pop();
  endtask

  task automatic test_hold_stall();
    logic [17:0] ea;
    logic [11:0] eb;
    logic [7:0]  held;
    frame_q = '{8'($urandom), 8'($urandom)};
    ea = exp_a();
    eb = exp_b();
    send_frame(0);
    held     = 8'($urandom);
    in_valid = 1'b1;
    in_data  = held;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (hs !== 4'b0011 || obs_a !== ea || obs_b !== eb) begin
        errors++; $display("FAIL stall_cycle%0d: got hs=%b a=%h b=%h expected hs=0011 a=%h b=%h", k, hs, obs_a, obs_b, ea, eb);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (hs !== 4'b1100) begin
      errors++; $display("FAIL stall_pop_no_accept: got %b expected %b", hs, 4'b1100);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame_q  = '{held};
    ea = exp_a();
    eb = exp_b();
    checks++;
    if (hs !== 4'b0011 || obs_a !== ea || obs_b !== eb) begin
      errors++; $display("FAIL stall_held_word: got hs=%b a=%h b=%h expected hs=0011 a=%h b=%h", hs, obs_a, obs_b, ea, eb);
    end
    pop();
  endtask

  task automatic test_overflow();
    int lens[4] = '{5, 2, 3, 4};
    logic [17:0] ea;
    logic [11:0] eb;
    foreach (lens[n]) begin
      frame_q.delete();
      for (int i = 0; i < lens[n]; i++)
        frame_q.push_back((n == 0) ? 8'hFF : 8'($urandom));
      ea = exp_a();
      eb = exp_b();
      send_frame(0);
      checks++;
      if (obs_a !== ea || obs_b !== eb) begin
        errors++; $display("FAIL ovf_len%0d: got a=%h b=%h expected a=%h b=%h", lens[n], obs_a, obs_b, ea, eb);
      end
      if (n == 0) begin
        checks++;
        if (obs_b !== {8'hFF, 1'b1, 2'd3, 1'b1}) begin
          errors++; $display("FAIL ovf_five_ff: got %h expected %h", obs_b, {8'hFF, 1'b1, 2'd3, 1'b1});
        end
      end
      pop();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] ea;
    logic [11:0] eb;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    apply_reset();
    frame_q = '{8'hAA};
    send_frame(0);
    checks++;
    if (obs_a !== {8'hAA, 1'b0, 8'd1, 1'b0} || obs_b !== {8'hAA, 1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL reset_mid_frame: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, {8'hAA, 1'b0, 8'd1, 1'b0}, {8'hAA, 1'b1, 2'd1, 1'b0});
    end
    // Reset while a result is held: discarded without emission.
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (hs !== 4'b1100 || obs_a !== 18'h0 || obs_b !== {8'h00, 1'b1, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_in_hold: got hs=%b a=%h b=%h expected hs=1100 a=0 b=%h", hs, obs_a, obs_b, {8'h00, 1'b1, 2'd0, 1'b0});
    end
    frame_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    ea = exp_a();
    eb = exp_b();
    send_frame(0);
    checks++;
    if (obs_a !== ea || obs_b !== eb) begin
      errors++; $display("FAIL after_reset_frame: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, ea, eb);
    end
    pop();
  endtask

  task automatic test_valid_toggle();
    logic [17:0] ea;
    logic [11:0] eb;
    frame_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    ea = exp_a();
    eb = exp_b();
    send_frame(2);
    checks++;
    if (hs !== 4'b0011 || obs_a !== ea || obs_b !== eb) begin
      errors++; $display("FAIL valid_toggle: got hs=%b a=%h b=%h expected hs=0011 a=%h b=%h", hs, obs_a, obs_b, ea, eb);
    end
    pop();
  endtask

  task automatic test_random();
    logic [17:0] ea;
    logic [11:0] eb;
    for (int f = 0; f < 40; f++) begin
      frame_q.delete();
      repeat ($urandom_range(1, 6)) frame_q.push_back(8'($urandom));
      exp_a_q.push_back(exp_a());
      exp_b_q.push_back(exp_b());
      send_frame(1);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      checks++;
      if (hs !== 4'b0011 || obs_a !== ea || obs_b !== eb) begin
        errors++; $display("FAIL random_frame%0d: got hs=%b a=%h b=%h expected hs=0011 a=%h b=%h", f, hs, obs_a, obs_b, ea, eb);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || obs_a !== ea) begin
        errors++; $display("FAIL random_hold%0d: got v=%b a=%h expected v=1 a=%h", f, out_valid_a, obs_a, ea);
      end
      pop();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_single_word();
    test_hold_stall();
    test_overflow();
    test_reset_mid_frame();
    test_valid_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
